// File: rtl/gpu_div_pkg.sv
// Shared types and widths for the GPU setup divider arbiter.
package gpu_div_pkg;
    localparam int DIV_NUM_W = 32;
    localparam int DIV_DEN_W = 22;
    localparam int REQ_ID_W  = 3;   // enough for up to 8 requesters
    localparam int MAX_TAG_W = 16;  // widest tag the side pipeline carries

    typedef struct packed {
        logic                 valid;
        logic [REQ_ID_W-1:0]  req_id;
        logic [MAX_TAG_W-1:0] tag;
        logic                 divzero;
        logic                 nsign;
    } div_side_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning upward from rr_ptr, pointer
// moves past the winner whenever a grant is issued.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] next_ptr;
    logic [PTR_W-1:0] idx;
    logic             found;
    int               sum;

    // NOTE: every variable gets a default before the loop so no path infers a latch.
    always_comb begin
        grant    = '0;
        next_ptr = rr_ptr;
        found    = 1'b0;
        idx      = '0;
        sum      = 0;
        if (enable) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                sum = int'(rr_ptr) + k;
                if (sum >= NUM_REQ) sum = sum - NUM_REQ;
                idx = PTR_W'(sum);
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    next_ptr   = (sum == NUM_REQ - 1) ? '0 : PTR_W'(sum + 1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            rr_ptr <= '0;
        else if (|grant)
            rr_ptr <= next_ptr;
    end
endmodule

// File: rtl/gpu_div_arbiter.sv
// Shares one fixed-latency signed divider between setup requesters, carrying
// id/tag/divide-by-zero status alongside and routing each quotient back.
module gpu_div_arbiter
    import gpu_div_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int OUTSIZE = 20,
    parameter int LATENCY = 6,
    parameter int TAGW    = 4   // at most MAX_TAG_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DIV_NUM_W-1:0] req_numerator,
    input  logic [NUM_REQ*DIV_DEN_W-1:0] req_denominator,
    input  logic [NUM_REQ*TAGW-1:0]      req_tag,
    output logic [DIV_NUM_W-1:0]         div_numerator,
    output logic [DIV_DEN_W-1:0]         div_denominator,
    input  logic [OUTSIZE-1:0]           div_quotient,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [OUTSIZE-1:0]           rsp_quotient,
    output logic [TAGW-1:0]              rsp_tag,
    output logic                         rsp_divzero,
    output logic                         busy
);
    logic [NUM_REQ-1:0]   grant;
    logic                 accept;
    logic [DIV_NUM_W-1:0] sel_num;
    logic [DIV_DEN_W-1:0] sel_den;
    logic [TAGW-1:0]      sel_tag;
    logic [REQ_ID_W-1:0]  sel_id;
    logic                 sel_zero;
    div_side_t            stage_in;
    div_side_t            side [LATENCY+1];
    div_side_t            last;
    logic [OUTSIZE-1:0]   sat;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clock  (clock),
        .reset  (reset),
        .enable (~(flush | reset)),
        .req    (req_valid),
        .grant  (grant)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    always_comb begin
        sel_num = '0;
        sel_den = '0;
        sel_tag = '0;
        sel_id  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_num = req_numerator[DIV_NUM_W*i +: DIV_NUM_W];
                sel_den = req_denominator[DIV_DEN_W*i +: DIV_DEN_W];
                sel_tag = req_tag[TAGW*i +: TAGW];
                sel_id  = REQ_ID_W'(i);
            end
        end
        sel_zero = (sel_den == '0);
        stage_in = '{valid: accept, req_id: sel_id, tag: MAX_TAG_W'(sel_tag),
                     divzero: sel_zero, nsign: sel_num[DIV_NUM_W-1]};
    end

    // A zero denominator issues 0/1 so the divider never sees it; the output saturates instead.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_numerator   <= '0;
            div_denominator <= '0;
        end else if (accept) begin
            div_numerator   <= sel_zero ? '0 : sel_num;
            div_denominator <= sel_zero ? DIV_DEN_W'(1) : sel_den;
        end
    end

    // One stage more than LATENCY: the last stage lines up with div_quotient after its capture edge.
    // NOTE: the side pipeline is plain flops, not a RAM, so every entry is reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= LATENCY; k++) side[k] <= '0;
        end else begin
            side[0] <= stage_in;
            for (int k = 1; k <= LATENCY; k++) side[k] <= side[k-1];
            if (flush)
                for (int k = 0; k <= LATENCY; k++) side[k].valid <= 1'b0;
        end
    end

    assign last = side[LATENCY];
    assign sat  = last.nsign ? {1'b1, {(OUTSIZE-1){1'b0}}} : {1'b0, {(OUTSIZE-1){1'b1}}};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid    <= '0;
            rsp_quotient <= '0;
            rsp_tag      <= '0;
            rsp_divzero  <= 1'b0;
        end else begin
            rsp_valid <= last.valid ? (NUM_REQ'(1) << last.req_id) : '0;
            if (last.valid) begin
                rsp_quotient <= last.divzero ? sat : div_quotient;
                rsp_tag      <= last.tag[TAGW-1:0];
                rsp_divzero  <= last.divzero;
            end
        end
    end

    always_comb begin
        busy = |rsp_valid;
        for (int k = 0; k <= LATENCY; k++) busy = busy | side[k].valid;
    end
endmodule
